dht22_poll_ctrl: RTL and testbench
==================================

# dht22_poll_ctrl

Periodic acquisition controller for the DHT22 single-wire reader. It owns the reader's `get` and reset inputs and schedules one read per poll period. After a fixed capture window it validates the 40-bit frame, retries failed frames up to a limit, and publishes decoded humidity and temperature with strobes. It sits between the reader and the application/register logic; the reader and this block run on the same 1 MHz `clk`.

## Interface
- `POLL_PERIOD`, 2_000_000: cycles between read starts, also the power-up delay before the first read (2 s at 1 MHz).
- `CAPTURE_WAIT`, 6000: cycles from end of request to frame sampling; covers the worst-case DHT22 frame.
- `MAX_RETRY`, 3: extra attempts after a bad frame before an error is declared.
- `CNT_W`, 22: width of the period/capture counter; must satisfy 2^CNT_W > POLL_PERIOD.

Ports:
- `clk`  in  1  clock (1 MHz).
- `reset`  in  1  synchronous, active-low.
- `enable`  in  1  level; 1 = periodic polling allowed.
- `force`  in  1  one-cycle pulse; starts a read early.
- `rd_rst_n`  out  1  reader reset, active-low.
- `rd_get`  out  1  reader request, active-low.
- `rd_data`  in  40  reader frame `{hum[15:0], temp[15:0], csum[7:0]}`.
- `humidity`  out  16  last good humidity, tenths of %RH.
- `temperature`  out  16  last good temperature, tenths of °C; encoding per Configuration.
- `valid`  out  1  sticky; set on first good frame.
- `sample_stb`  out  1  one-cycle pulse per good frame.
- `err_stb`  out  1  one-cycle pulse when retries are exhausted.
- `err_cnt`  out  8  count of exhausted-retry events, saturating at 255.

## Operation
- Reset values while `reset`=0: state WAIT_PERIOD, counter 0, retry 0, `rd_rst_n`=0, `rd_get`=1, `humidity`=0, `temperature`=0, `valid`=0, `sample_stb`=0, `err_stb`=0, `err_cnt`=0.
- States:
  - **WAIT_PERIOD**: counter increments each cycle, with `rd_rst_n`=1 and `rd_get`=1.
    - counter==POLL_PERIOD-1 with `enable`=1 → RST_RD, counter cleared.
    - `force`=1 with `enable`=1 → RST_RD immediately, counter cleared.
    - `enable`=0: counter holds at POLL_PERIOD-1 and `force` is ignored.
  - **RST_RD**: 1 cycle, `rd_rst_n`=0. This clears the reader's stale data to zero. → REQ.
  - **REQ**: 2 cycles, `rd_get`=0. → CAPTURE.
  - **CAPTURE**: CAPTURE_WAIT cycles, `rd_get`=1. → CHECK.
  - **CHECK**: 1 cycle, samples `rd_data`.
    - Good frame: update outputs, retry=0 → WAIT_PERIOD.
    - Bad frame with retry<MAX_RETRY: retry+1 → WAIT_PERIOD. The DHT22 needs ≥2 s between reads, so a retry also waits a full period.
    - Bad frame with retry==MAX_RETRY: `err_stb` pulse, `err_cnt`+1 saturating, retry=0 → WAIT_PERIOD.
- Good frame means both:
  - `(d[39:32]+d[31:24]+d[23:16]+d[15:8]) mod 256 == d[7:0]`, and
  - `d != 0`. The all-zero frame left by RST_RD passes the checksum but means no response, so it is bad.
- On a bad frame, `humidity`, `temperature` and `valid` are unchanged.
- Once started, a read (RST_RD…CHECK) always completes. `enable`=0 and `force` have no effect until WAIT_PERIOD.

## Timing
- Read start to `sample_stb` high: 1 + 2 + CAPTURE_WAIT + 1 cycles.
  - `force` at cycle t → `rd_rst_n` low at t+1, `rd_get` low at t+2..t+3.
  - `humidity`/`temperature`/`valid`/`sample_stb` update at t+4+CAPTURE_WAIT.
- `sample_stb` and `err_stb` are registered, 1 cycle wide, and never high together.
- `force` and counter terminal count in the same cycle start a single read, not two.
- `reset` low mid-read: abort immediately, all outputs to reset values, next read after a full POLL_PERIOD.

## Configuration
- `DHT22_CTRL_SIGNED_TEMP_EN`:
  - Defined: `temperature` is two's complement; raw sign-magnitude (bit15 = sign, 14:0 = magnitude) is converted at CHECK. Example: raw 0x8065 → 0xFF9B (−10.1 °C).
  - Undefined: `temperature` = raw `d[23:8]` unmodified.
  - Latency is identical in both builds.

## Structure
- Package `dht22_ctrl_pkg`:
  - state enum (WAIT_PERIOD, RST_RD, REQ, CAPTURE, CHECK);
  - frame field offsets (HUM_MSB=39, TEMP_MSB=23, CSUM_MSB=7);
  - REQ_CYCLES=2.
- Sub-module `dht22_frame_check` (combinational):
  - input 40-bit frame;
  - outputs `good`, `hum[15:0]`, `temp[15:0]` (macro-dependent conversion).
- The controller FSM, counter and retry logic stay in `dht22_poll_ctrl`.

## Test plan
- POLL_PERIOD=100, CAPTURE_WAIT=20, reader model returns 0x0292_0065_F9 → `sample_stb` at cycle 100+24 after reset release; `humidity`=0x0292 (65.8 %), `temperature`=0x0065, `valid`=1.
- Reader returns 0x0292_8065_79, with and without `DHT22_CTRL_SIGNED_TEMP_EN` → `temperature`=0xFF9B vs 0x8065.
- Reader never responds (data stays 0), MAX_RETRY=3 → 4 reads, then one `err_stb`, `err_cnt`=1, `valid` still 0.
- Bad checksum on first read, good on second → no `err_stb`, `sample_stb` one period later, retry counter cleared.
- `force` pulse mid-CAPTURE → ignored; `force` in WAIT_PERIOD with `enable`=0 → ignored; with `enable`=1 → `rd_rst_n` low next cycle.
- `reset` low during CAPTURE → `rd_rst_n`=0, `rd_get`=1, outputs cleared; no read starts before POLL_PERIOD after release.

Source files
------------

// File: rtl/dht22_ctrl_pkg.sv
// dht22_ctrl_pkg
//   Shared definitions for the DHT22 poll controller: FSM state encoding,
//   bit offsets of the fields inside the 40-bit reader frame, request
//   length and the frame checksum helper.
//   Optional feature macro used by the slice: DHT22_CTRL_SIGNED_TEMP_EN.
package dht22_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_PERIOD,
    RST_RD,
    REQ,
    CAPTURE,
    CHECK
  } state_t;

  // Frame layout {hum[15:0], temp[15:0], csum[7:0]}
  localparam int unsigned HUM_MSB  = 39;
  localparam int unsigned TEMP_MSB = 23;
  localparam int unsigned CSUM_MSB = 7;

  // Cycles the reader's get input is held low per request
  localparam int unsigned REQ_CYCLES = 2;

  // Modulo-256 sum of the four data bytes
  function automatic logic [7:0] frame_sum(input logic [39:0] d);
    logic [7:0] s;
    s = d[39:32] + d[31:24];
    s = s + d[23:16];
    s = s + d[15:8];
    return s;
  endfunction

endpackage

// File: rtl/dht22_frame_check.sv
// dht22_frame_check
//   Combinational validation and field extraction for one DHT22 frame.
//   Macro: DHT22_CTRL_SIGNED_TEMP_EN -- when defined, temperature is
//   converted from the sensor's sign-magnitude form to two's complement.
// Ports:
//   frame_i  in  40  reader frame {hum, temp, csum}
//   good_o   out 1   checksum matches and frame is not all-zero
//   hum_o    out 16  humidity field
//   temp_o   out 16  temperature (raw or two's complement per macro)
module dht22_frame_check
  import dht22_ctrl_pkg::*;
(
  input  logic [39:0] frame_i,
  output logic        good_o,
  output logic [15:0] hum_o,
  output logic [15:0] temp_o
);

  logic [15:0] raw_temp;
  logic [7:0]  csum;

  assign hum_o    = frame_i[HUM_MSB -: 16];
  assign raw_temp = frame_i[TEMP_MSB -: 16];
  assign csum     = frame_i[CSUM_MSB -: 8];

  // The all-zero frame left behind by a reader reset passes the checksum
  // but means the sensor never answered.
  assign good_o = (frame_sum(frame_i) == csum) && (frame_i != '0);

`ifdef DHT22_CTRL_SIGNED_TEMP_EN
  // Negative zero (0x8000) maps to 0x0000.
  assign temp_o = raw_temp[15] ? (16'd0 - {1'b0, raw_temp[14:0]}) : raw_temp;
`else
  assign temp_o = raw_temp;
`endif

endmodule

// File: rtl/dht22_poll_ctrl.sv
// dht22_poll_ctrl
//   Periodic acquisition controller for the DHT22 single-wire reader.
//   Starts one read per POLL_PERIOD (or early on force_i), waits a fixed
//   capture window, validates the frame, retries bad frames up to
//   MAX_RETRY times and publishes humidity/temperature with strobes.
//   Macro: DHT22_CTRL_SIGNED_TEMP_EN (see dht22_frame_check).
// Ports:
//   clk            in   1   clock, 1 MHz
//   reset          in   1   synchronous, active-low
//   enable_i       in   1   level, allows periodic polling
//   force_i        in   1   one-cycle pulse, starts a read early
//   rd_rst_n_o     out  1   reader reset, active-low
//   rd_get_o       out  1   reader request, active-low
//   rd_data_i      in   40  reader frame {hum, temp, csum}
//   humidity_o     out  16  last good humidity
//   temperature_o  out  16  last good temperature
//   valid_o        out  1   sticky, set on first good frame
//   sample_stb_o   out  1   one-cycle pulse per good frame
//   err_stb_o      out  1   one-cycle pulse when retries are exhausted
//   err_cnt_o      out  8   exhausted-retry events, saturating at 255
module dht22_poll_ctrl
  import dht22_ctrl_pkg::*;
#(
  parameter int unsigned POLL_PERIOD  = 2_000_000,
  parameter int unsigned CAPTURE_WAIT = 6000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        force_i,
  output logic        rd_rst_n_o,
  output logic        rd_get_o,
  input  logic [39:0] rd_data_i,
  output logic [15:0] humidity_o,
  output logic [15:0] temperature_o,
  output logic        valid_o,
  output logic        sample_stb_o,
  output logic        err_stb_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   PERIOD_LAST  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0]   REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CAPTURE_LAST = CNT_W'(CAPTURE_WAIT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               rd_rst_n_q, rd_rst_n_d;
  logic               rd_get_q, rd_get_d;
  logic [15:0]        hum_q, hum_d;
  logic [15:0]        temp_q, temp_d;
  logic               valid_q, valid_d;
  logic               sample_stb_q, sample_stb_d;
  logic               err_stb_q, err_stb_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               frame_good;
  logic [15:0]        frame_hum;
  logic [15:0]        frame_temp;

  dht22_frame_check u_frame_check (
    .frame_i (rd_data_i),
    .good_o  (frame_good),
    .hum_o   (frame_hum),
    .temp_o  (frame_temp)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WAIT_PERIOD;
      cnt_q        <= '0;
      retry_q      <= '0;
      rd_rst_n_q   <= 1'b0;
      rd_get_q     <= 1'b1;
      hum_q        <= '0;
      temp_q       <= '0;
      valid_q      <= 1'b0;
      sample_stb_q <= 1'b0;
      err_stb_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      rd_rst_n_q   <= rd_rst_n_d;
      rd_get_q     <= rd_get_d;
      hum_q        <= hum_d;
      temp_q       <= temp_d;
      valid_q      <= valid_d;
      sample_stb_q <= sample_stb_d;
      err_stb_q    <= err_stb_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    hum_d        = hum_q;
    temp_d       = temp_q;
    valid_d      = valid_q;
    sample_stb_d = 1'b0;
    err_stb_d    = 1'b0;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      WAIT_PERIOD: begin
        // Terminal count and force in the same cycle start a single read.
        // With enable low the counter parks at the terminal value so a
        // read starts as soon as polling is re-enabled.
        if (enable_i && (force_i || (cnt_q == PERIOD_LAST))) begin
          state_d = RST_RD;
          cnt_d   = '0;
        end else if (cnt_q != PERIOD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RST_RD: begin
        state_d = REQ;
        cnt_d   = '0;
      end

      REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CAPTURE: begin
        if (cnt_q == CAPTURE_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CHECK: begin
        // A retry also waits a full period: the sensor needs >= 2 s
        // between reads.
        state_d = WAIT_PERIOD;
        cnt_d   = '0;
        if (frame_good) begin
          hum_d        = frame_hum;
          temp_d       = frame_temp;
          valid_d      = 1'b1;
          sample_stb_d = 1'b1;
          retry_d      = '0;
        end else if (retry_q == RETRY_LIMIT) begin
          err_stb_d = 1'b1;
          retry_d   = '0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_PERIOD;
        cnt_d   = '0;
      end
    endcase

    // Reader controls are registered from the next state so they line up
    // with the state they belong to and take their reset values in reset.
    rd_rst_n_d = (state_d != RST_RD);
    rd_get_d   = (state_d != REQ);
  end

  assign rd_rst_n_o    = rd_rst_n_q;
  assign rd_get_o      = rd_get_q;
  assign humidity_o    = hum_q;
  assign temperature_o = temp_q;
  assign valid_o       = valid_q;
  assign sample_stb_o  = sample_stb_q;
  assign err_stb_o     = err_stb_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_dht22_poll_ctrl.sv
// tb_dht22_poll_ctrl
//   Directed self-checking bench for dht22_poll_ctrl with a short poll
//   period (100) and capture window (20). A small reader model clears its
//   frame on rd_rst_n low and loads the scripted response while rd_get is
//   low (if responding).
module tb_dht22_poll_ctrl;

  localparam int unsigned PP = 100;
  localparam int unsigned CW = 20;
  localparam int LAT = 1 + 2 + CW + 1;

`ifdef DHT22_CTRL_SIGNED_TEMP_EN
  localparam logic [15:0] TEMP_NEG = 16'hFF9B;
`else
  localparam logic [15:0] TEMP_NEG = 16'h8065;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        force_p;
  logic        rd_rst_n;
  logic        rd_get;
  logic [39:0] rd_data = '0;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        valid;
  logic        sample_stb;
  logic        err_stb;
  logic [7:0]  err_cnt;

  logic        respond = 1'b0;
  logic [39:0] resp    = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dht22_poll_ctrl #(
    .POLL_PERIOD  (PP),
    .CAPTURE_WAIT (CW),
    .MAX_RETRY    (3),
    .CNT_W        (22)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable),
    .force_i       (force_p),
    .rd_rst_n_o    (rd_rst_n),
    .rd_get_o      (rd_get),
    .rd_data_i     (rd_data),
    .humidity_o    (humidity),
    .temperature_o (temperature),
    .valid_o       (valid),
    .sample_stb_o  (sample_stb),
    .err_stb_o     (err_stb),
    .err_cnt_o     (err_cnt)
  );

  // Reader model
  always @(posedge clk) begin
    if (!rd_rst_n) rd_data <= '0;
    else if (!rd_get && respond) rd_data <= resp;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input int which);
    case (which)
      0:       return !rd_rst_n;
      1:       return sample_stb;
      default: return err_stb;
    endcase
  endfunction

  // Number of negedges until the selected event is seen, -1 on timeout
  task automatic wait_sig(input int which, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (hit(which)) begin
        n = i;
        break;
      end
    end
  endtask

  // Four unanswered reads one period apart, error strobe on the last one.
  task automatic run_err_seq(input logic [7:0] exp_cnt, input logic exp_valid,
                             input logic [15:0] exp_hum);
    int n;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, 300, n);
      check("noresp_start", 40'(n), 40'(PP));
      repeat (LAT - 1) @(negedge clk);
      check("noresp_pre_err", 40'(err_stb), 40'(0));
      @(negedge clk);
      check("noresp_err_stb", 40'(err_stb), 40'(k == 3));
      check("noresp_no_stb", 40'(sample_stb), 40'(0));
    end
    check("noresp_err_cnt", 40'(err_cnt), 40'(exp_cnt));
    check("noresp_valid", 40'(valid), 40'(exp_valid));
    check("noresp_hum_hold", 40'(humidity), 40'(exp_hum));
    @(negedge clk);
    check("noresp_err_pulse", 40'(err_stb), 40'(0));
  endtask

  initial begin
    int n;
    int lows;
    reset   = 1'b0;
    enable  = 1'b1;
    force_p = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rd_rst_n", 40'(rd_rst_n), 40'(0));
    check("rst_rd_get", 40'(rd_get), 40'(1));
    check("rst_hum", 40'(humidity), 40'(0));
    check("rst_temp", 40'(temperature), 40'(0));
    check("rst_valid", 40'(valid), 40'(0));
    check("rst_sample_stb", 40'(sample_stb), 40'(0));
    check("rst_err_stb", 40'(err_stb), 40'(0));
    check("rst_err_cnt", 40'(err_cnt), 40'(0));

    // First periodic read, good frame
    respond = 1'b1;
    resp    = 40'h0292_0065_F9;
    reset   = 1'b1;
    wait_sig(0, 300, n);
    check("first_start", 40'(n), 40'(PP));
    check("get_idle_in_rst", 40'(rd_get), 40'(1));
    @(negedge clk);
    check("req_get_low0", 40'(rd_get), 40'(0));
    check("req_rst_n_high", 40'(rd_rst_n), 40'(1));
    @(negedge clk);
    check("req_get_low1", 40'(rd_get), 40'(0));
    @(negedge clk);
    check("capture_get_high", 40'(rd_get), 40'(1));
    wait_sig(1, 60, n);
    check("first_latency", 40'(n), 40'(LAT - 3));
    check("first_hum", 40'(humidity), 40'h0292);
    check("first_temp", 40'(temperature), 40'h0065);
    check("first_valid", 40'(valid), 40'(1));
    check("first_no_err", 40'(err_stb), 40'(0));
    @(negedge clk);
    check("stb_one_cycle", 40'(sample_stb), 40'(0));

    // Forced read, negative temperature
    resp    = 40'h0292_8065_79;
    force_p = 1'b1;
    @(negedge clk);
    force_p = 1'b0;
    check("force_start", 40'(rd_rst_n), 40'(0));
    wait_sig(1, 60, n);
    check("force_latency", 40'(n), 40'(LAT));
    check("neg_temp", 40'(temperature), 40'(TEMP_NEG));
    check("neg_hum", 40'(humidity), 40'h0292);
    @(negedge clk);

    // Polling disabled: force ignored, no periodic read
    enable  = 1'b0;
    force_p = 1'b1;
    @(negedge clk);
    force_p = 1'b0;
    check("force_disabled", 40'(rd_rst_n), 40'(1));
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (!rd_rst_n) lows++;
    end
    check("disabled_no_read", 40'(lows), 40'(0));

    // Re-enable after the counter parked at terminal count: read starts next cycle
    resp   = 40'h0292_0065_F8;
    enable = 1'b1;
    @(negedge clk);
    check("enable_resume", 40'(rd_rst_n), 40'(0));
    repeat (10) @(negedge clk);
    force_p = 1'b1;
    @(negedge clk);
    force_p = 1'b0;
    check("force_in_capture", 40'(rd_rst_n), 40'(1));
    repeat (LAT - 11) @(negedge clk);
    check("bad_no_stb", 40'(sample_stb), 40'(0));
    check("bad_no_err", 40'(err_stb), 40'(0));
    check("bad_hold_hum", 40'(humidity), 40'h0292);
    check("bad_hold_temp", 40'(temperature), 40'(TEMP_NEG));

    // Retry one full period later, good frame this time
    resp = 40'h0100_00FA_FB;
    wait_sig(0, 300, n);
    check("retry_period", 40'(n), 40'(PP));
    wait_sig(1, 60, n);
    check("retry_latency", 40'(n), 40'(LAT));
    check("retry_hum", 40'(humidity), 40'h0100);
    check("retry_temp", 40'(temperature), 40'h00FA);
    check("retry_no_err", 40'(err_stb), 40'(0));

    // Sensor stops answering: retry counter must have been cleared
    respond = 1'b0;
    run_err_seq(8'd1, 1'b1, 16'h0100);

    // Reset during capture
    @(negedge clk);
    respond = 1'b1;
    force_p = 1'b1;
    @(negedge clk);
    force_p = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rd_rst_n", 40'(rd_rst_n), 40'(0));
    check("abort_rd_get", 40'(rd_get), 40'(1));
    check("abort_hum", 40'(humidity), 40'(0));
    check("abort_valid", 40'(valid), 40'(0));
    check("abort_err_cnt", 40'(err_cnt), 40'(0));
    respond = 1'b0;
    reset   = 1'b1;
    run_err_seq(8'd1, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
